instr_ram_loader: RTL and testbench
===================================

INSTR_RAM_LOADER -- requirements
Module: instr_ram_loader

Interface
REQ-001 The block SHALL take parameters: DATA_WIDTH, default 28, instruction word width; ADDR_WIDTH, default 8, memory depth DEPTH = 2^ADDR_WIDTH words; DEFAULT_WORD, default 28'h0, value returned for unmapped or unavailable reads.
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 iAddress  input  16  instruction fetch address.
REQ-005 oInstruction  output  DATA_WIDTH  registered fetched instruction.
REQ-006 iLoadStart  input  1  one-cycle pulse that begins a load session.
REQ-007 iLoadLength  input  ADDR_WIDTH+1  number of words to load, sampled with iLoadStart.
REQ-008 iByte  input  8  load data byte.
REQ-009 iByteValid  input  1  iByte is valid.
REQ-010 oByteReady  output  1  block accepts iByte this cycle.
REQ-011 oHoldCPU  output  1  high while a load is in progress; the CPU stalls fetch.
REQ-012 oLoadDone  output  1  one-cycle pulse on load completion.
REQ-013 oLoadError  output  1  one-cycle pulse on a rejected or failed load.

Function
REQ-014 Storage SHALL be DEPTH words of DATA_WIDTH bits, all initialised to DEFAULT_WORD at configuration.
REQ-015 Fetch latency SHALL be 1 cycle: oInstruction <= mem[iAddress] when iAddress < DEPTH, else DEFAULT_WORD.
REQ-016 While oHoldCPU=1, oInstruction SHALL be DEFAULT_WORD.
REQ-017 The FSM SHALL have states IDLE, LOAD, CHECK (macro only) and DONE.
REQ-018 IDLE: oByteReady=0, oHoldCPU=0; iLoadStart with 1 <= iLoadLength <= DEPTH goes to LOAD with word pointer 0 and byte index 0.
REQ-019 IDLE: iLoadStart with iLoadLength=0 or > DEPTH SHALL stay in IDLE and pulse oLoadError for the next cycle.
REQ-020 LOAD: oByteReady=1, oHoldCPU=1; a byte transfers only on a cycle with iByteValid=1 and oByteReady=1.
REQ-021 A word SHALL occupy BPW = ceil(DATA_WIDTH/8) bytes (4 by default), least significant byte first; bits above DATA_WIDTH in the last byte are discarded.
REQ-022 On the BPW-th byte the assembled word SHALL be written to mem[pointer] in the same edge and the pointer SHALL increment.
REQ-023 After the word at pointer iLoadLength-1 is written, the FSM SHALL go to CHECK if compiled in, otherwise to DONE.
REQ-024 iLoadStart SHALL be ignored outside IDLE.
REQ-025 Stalls (iByteValid=0) SHALL hold all load state, with no timeout.
REQ-026 DONE SHALL last one cycle: oLoadDone=1 (oLoadError=1 instead on checksum failure), oHoldCPU=1, then return to IDLE.

Reset
REQ-027 Reset SHALL force state IDLE, pointer 0, byte index 0, checksum 0, oInstruction=DEFAULT_WORD, oByteReady=0, oHoldCPU=0, oLoadDone=0, oLoadError=0.
REQ-028 Reset SHALL NOT clear memory contents; a reset mid-load aborts the session, keeps words already written, and does not assert oLoadDone.

Configuration
REQ-029 With INSTR_RAM_CHECKSUM_EN defined, LOAD SHALL keep an 8-bit modular sum of all data bytes and go to CHECK after the last word.
REQ-030 In CHECK (oByteReady=1, oHoldCPU=1) the block SHALL accept one byte; if (sum + byte) mod 256 != 0, the DONE cycle SHALL pulse oLoadError instead of oLoadDone; written words are kept.
REQ-031 Without INSTR_RAM_CHECKSUM_EN, the CHECK state and the checksum logic SHALL be absent, and LOAD goes directly to DONE.

Verification
REQ-032 Reset, then iAddress=5 -> oInstruction=28'h0 one cycle later; oHoldCPU=0.
REQ-033 Load of length 2, bytes 78 56 34 12 EF CD AB 0F -> oLoadDone pulses once; fetch at 0 returns 28'h2345678 and fetch at 1 returns 28'hFABCDEF, each one cycle after the address.
REQ-034 iLoadStart with iLoadLength=0, then with 257 (DEPTH=256) -> one oLoadError pulse each; no oByteReady; memory unchanged.
REQ-035 Reset asserted after 3 bytes of word 1 in a 2-word load -> state IDLE; word 0 kept; word 1 unchanged; no oLoadDone.
REQ-036 iByteValid toggled randomly through a 4-word load, plus iLoadStart pulsed mid-load -> contents are identical to an unstalled load; iLoadStart has no effect.
REQ-037 With INSTR_RAM_CHECKSUM_EN, 1-word load of 01 02 03 04 with checksum F6 -> oLoadDone; with checksum F7 -> oLoadError and word 0 = 28'h4030201.

Source files
------------

// File: rtl/instr_ram_loader.sv
// Instruction RAM with a byte-serial loader that stalls the CPU while a load runs.
// Optional checksum stage compiled in with `define INSTR_RAM_CHECKSUM_EN.
module instr_ram_loader #(
  parameter int                    DATA_WIDTH   = 28,
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [15:0]           iAddress,
  output logic [DATA_WIDTH-1:0] oInstruction,
  input  logic                  iLoadStart,
  input  logic [ADDR_WIDTH:0]   iLoadLength,
  input  logic [7:0]            iByte,
  input  logic                  iByteValid,
  output logic                  oByteReady,
  output logic                  oHoldCPU,
  output logic                  oLoadDone,
  output logic                  oLoadError
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BPW   = (DATA_WIDTH + 7) / 8;
  localparam int BIW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int LW    = ADDR_WIDTH + 1;

`ifdef INSTR_RAM_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2,
    S_CHECK = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH-1:0]   last_ptr;
  logic [BIW-1:0]          byte_idx;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    byte_fire;
  logic                    load_fire;
  logic                    word_end;
  logic                    wr_en;
  logic                    len_ok;
  logic                    start_ok;
  logic                    hold_next;
  logic                    in_range;

  // Words are stored XOR DEFAULT_WORD, so the all-zero power-up contents of the
  // RAM read back as DEFAULT_WORD without any initialisation pass.
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef INSTR_RAM_CHECKSUM_EN
  logic [7:0]              csum;
  logic [7:0]              csum_sum;
  assign csum_sum = csum + iByte;
`endif

  assign byte_fire = iByteValid & oByteReady;
  assign load_fire = byte_fire & (state == S_LOAD);
  assign word_end  = (byte_idx == BIW'(BPW - 1));
  assign wr_en     = load_fire & word_end & ~Reset;
  assign len_ok    = (iLoadLength != '0) && (iLoadLength <= LW'(DEPTH));
  assign start_ok  = (state == S_IDLE) && iLoadStart && len_ok;
  // Hold is high in the next cycle unless we sit in IDLE or leave DONE now.
  assign hold_next = start_ok || ((state != S_IDLE) && (state != S_DONE));

  generate
    if (ADDR_WIDTH >= 16) begin : g_range_full
      assign in_range = 1'b1;
    end else begin : g_range_cmp
      assign in_range = ~|iAddress[15:ADDR_WIDTH];
    end
  endgenerate

  // Byte lanes: all but the last are buffered; the last comes straight from
  // iByte on the completing edge, truncated to DATA_WIDTH.
  generate
    if (BPW == 1) begin : g_single_lane
      assign wr_data = iByte[DATA_WIDTH-1:0];
    end else begin : g_multi_lane
      logic [(BPW-1)*8-1:0] word_buf;
      for (genvar gi = 0; gi < BPW - 1; gi++) begin : g_lane
        always_ff @(posedge Clock) begin
          if (load_fire && (byte_idx == BIW'(gi))) begin
            word_buf[gi*8 +: 8] <= iByte;
          end
        end
        assign wr_data[gi*8 +: 8] = word_buf[gi*8 +: 8];
      end
      assign wr_data[DATA_WIDTH-1:(BPW-1)*8] = iByte[DATA_WIDTH-1-(BPW-1)*8:0];
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem[ptr] <= wr_data ^ DEFAULT_WORD;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      oInstruction <= DEFAULT_WORD;
    end else if (hold_next || !in_range) begin
      oInstruction <= DEFAULT_WORD;
    end else begin
      oInstruction <= mem[iAddress[ADDR_WIDTH-1:0]] ^ DEFAULT_WORD;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      last_ptr   <= '0;
      byte_idx   <= '0;
      oByteReady <= 1'b0;
      oHoldCPU   <= 1'b0;
      oLoadDone  <= 1'b0;
      oLoadError <= 1'b0;
`ifdef INSTR_RAM_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      oLoadDone  <= 1'b0;
      oLoadError <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iLoadStart) begin
            if (len_ok) begin
              state      <= S_LOAD;
              ptr        <= '0;
              byte_idx   <= '0;
              last_ptr   <= ADDR_WIDTH'(iLoadLength - 1'b1);
              oByteReady <= 1'b1;
              oHoldCPU   <= 1'b1;
`ifdef INSTR_RAM_CHECKSUM_EN
              csum       <= '0;
`endif
            end else begin
              oLoadError <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (byte_fire) begin
`ifdef INSTR_RAM_CHECKSUM_EN
            csum <= csum_sum;
`endif
            if (word_end) begin
              byte_idx <= '0;
              ptr      <= ptr + 1'b1;
              if (ptr == last_ptr) begin
`ifdef INSTR_RAM_CHECKSUM_EN
                state      <= S_CHECK;
`else
                state      <= S_DONE;
                oByteReady <= 1'b0;
                oLoadDone  <= 1'b1;
`endif
              end
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end

`ifdef INSTR_RAM_CHECKSUM_EN
        S_CHECK: begin
          if (byte_fire) begin
            state      <= S_DONE;
            oByteReady <= 1'b0;
            if (csum_sum == 8'd0) begin
              oLoadDone  <= 1'b1;
            end else begin
              oLoadError <= 1'b1;
            end
          end
        end
`endif

        S_DONE: begin
          state    <= S_IDLE;
          oHoldCPU <= 1'b0;
        end

        default: begin
          state      <= S_IDLE;
          oByteReady <= 1'b0;
          oHoldCPU   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_ram_loader.sv
// Directed bench for instr_ram_loader: scoreboard of expected fetch words
// built from a reference memory image; checksum steps run when INSTR_RAM_CHECKSUM_EN is set.
module tb_instr_ram_loader;
  localparam int DW    = 28;
  localparam int AW    = 8;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 256;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [15:0]   iAddress;
  logic [DW-1:0] oInstruction;
  logic          iLoadStart;
  logic [AW:0]   iLoadLength;
  logic [7:0]    iByte;
  logic          iByteValid;
  logic          oByteReady;
  logic          oHoldCPU;
  logic          oLoadDone;
  logic          oLoadError;

  always #5 Clock = ~Clock;

  instr_ram_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iAddress    (iAddress),
    .oInstruction(oInstruction),
    .iLoadStart  (iLoadStart),
    .iLoadLength (iLoadLength),
    .iByte       (iByte),
    .iByteValid  (iByteValid),
    .oByteReady  (oByteReady),
    .oHoldCPU    (oHoldCPU),
    .oLoadDone   (oLoadDone),
    .oLoadError  (oLoadError)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int ready_cnt = 0;
  int stall_pct = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [7:0]    sum;

  always @(negedge Clock) begin
    if (oLoadDone)  done_cnt++;
    if (oLoadError) err_cnt++;
    if (oByteReady) ready_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: bench did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fetch(input int addr);
    logic [DW-1:0] e;
    iAddress = 16'(addr);
    e = '0;
    if (addr < DEPTH) e = model_mem[addr];
    exp_q.push_back(e);
    step();
    $display("fetch addr=%0d instr=%07h", addr, oInstruction);
    check($sformatf("fetch[%0d]", addr), 32'(oInstruction), 32'(exp_q.pop_front()));
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    if (stall_pct > 0) begin
      repeat ($urandom_range(3)) begin
        iByteValid = 1'b0;
        iByte      = 8'($urandom);
        step();
      end
    end
    while (!oByteReady && guard < 16) begin
      step();
      guard++;
    end
    check("byte_ready", 32'(oByteReady), 32'd1);
    iByte      = b;
    iByteValid = 1'b1;
    step();
    iByteValid = 1'b0;
    sum        = sum + b;
  endtask

  task automatic send_word(input int addr, input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    model_mem[addr] = w[DW-1:0];
  endtask

  task automatic start_load(input int len);
    iLoadStart  = 1'b1;
    iLoadLength = LW'(len);
    step();
    iLoadStart  = 1'b0;
    sum         = 8'd0;
    $display("load start len=%0d", len);
  endtask

  task automatic end_load(input logic expect_err);
`ifdef INSTR_RAM_CHECKSUM_EN
    logic [7:0] cb;
    cb = 8'(8'd0 - sum) + 8'(expect_err);
    send_byte(cb);
`endif
    check("hold_in_done", 32'(oHoldCPU), 32'd1);
    check("instr_in_done", 32'(oInstruction), 32'd0);
    check("done_pulse", 32'(oLoadDone), 32'(!expect_err));
    check("error_pulse", 32'(oLoadError), 32'(expect_err));
    step();
    check("hold_released", 32'(oHoldCPU), 32'd0);
    check("done_cleared", 32'(oLoadDone), 32'd0);
    $display("load end done=%0d err=%0d", done_cnt, err_cnt);
  endtask

  initial begin
    int d0, e0, r0;
    Reset = 1'b1; iAddress = '0; iLoadStart = 1'b0; iLoadLength = '0;
    iByte = '0; iByteValid = 1'b0; sum = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    step();
    step();
    check("rst_instr", 32'(oInstruction), 32'd0);
    check("rst_hold", 32'(oHoldCPU), 32'd0);
    check("rst_ready", 32'(oByteReady), 32'd0);
    check("rst_done", 32'(oLoadDone), 32'd0);
    check("rst_error", 32'(oLoadError), 32'd0);
    Reset = 1'b0;

    fetch(5);
    check("hold_idle", 32'(oHoldCPU), 32'd0);

    // Two-word load with known bytes
    d0 = done_cnt;
    start_load(2);
    check("ready_load", 32'(oByteReady), 32'd1);
    check("hold_load", 32'(oHoldCPU), 32'd1);
    iAddress = 16'd0;
    send_word(0, 32'h12345678);
    check("instr_held", 32'(oInstruction), 32'd0);
    send_word(1, 32'h0FABCDEF);
    end_load(1'b0);
    check("done_count_basic", 32'(done_cnt - d0), 32'd1);
    fetch(0);
    fetch(1);
    fetch(2);

    // Rejected lengths
    r0 = ready_cnt;
    e0 = err_cnt;
    start_load(0);
    check("err_len0", 32'(oLoadError), 32'd1);
    check("ready_len0", 32'(oByteReady), 32'd0);
    step();
    check("err_len0_cleared", 32'(oLoadError), 32'd0);
    start_load(257);
    check("err_len257", 32'(oLoadError), 32'd1);
    check("hold_len257", 32'(oHoldCPU), 32'd0);
    step();
    check("err_len257_cleared", 32'(oLoadError), 32'd0);
    check("err_count", 32'(err_cnt - e0), 32'd2);
    check("ready_count", 32'(ready_cnt - r0), 32'd0);
    fetch(0);
    fetch(1);

    // Reset in the middle of word 1
    d0 = done_cnt;
    start_load(2);
    send_word(0, 32'h11223344);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    Reset = 1'b1;
    step();
    check("midrst_hold", 32'(oHoldCPU), 32'd0);
    check("midrst_ready", 32'(oByteReady), 32'd0);
    Reset = 1'b0;
    step();
    step();
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    fetch(0);
    fetch(1);

    // Random stalls and a stray start pulse during a 4-word load
    stall_pct = 1;
    d0 = done_cnt;
    start_load(4);
    for (int w = 0; w < 4; w++) begin
      send_word(w, $urandom);
      if (w == 1) begin
        iLoadStart  = 1'b1;
        iLoadLength = LW'(1);
        step();
        iLoadStart  = 1'b0;
      end
    end
    end_load(1'b0);
    stall_pct = 0;
    check("done_count_stall", 32'(done_cnt - d0), 32'd1);
    for (int a = 0; a < 5; a++) fetch(a);
    fetch(256);
    fetch(16'h8001);

    // Full-depth load
    d0 = done_cnt;
    start_load(DEPTH);
    for (int a = 0; a < DEPTH; a++) send_word(a, (32'(a) * 32'h01010101) ^ 32'h5A5A0F0F);
    end_load(1'b0);
    check("done_count_full", 32'(done_cnt - d0), 32'd1);
    fetch(0);
    fetch(128);
    fetch(255);
    fetch(256);

`ifdef INSTR_RAM_CHECKSUM_EN
    start_load(1);
    send_word(0, 32'h04030201);
    end_load(1'b0);
    fetch(0);
    start_load(1);
    send_word(0, 32'h04030201);
    end_load(1'b1);
    fetch(0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
